tick_period_meter: RTL and testbench

Receiving end of the divided-clock tick outputs. Takes a slow square wave or tick line (e.g. the 500 ms toggle from the clock divider, or an external signal), synchronises it, and measures its period and high time in system-clock cycles. Publishes one measurement per rising edge, flags a stalled or missing tick, and keeps a 4-bit wrap-around count of measurements for the display path.

---
 rtl/tick_period_meter_pkg.sv | 17 +
 rtl/tick_period_meter_sync_edge_det.sv | 32 +++
 rtl/tick_period_meter.sv | 96 +++++++++
 tb/tb_tick_period_meter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/tick_period_meter_pkg.sv
// Shared constants and encodings for the tick measurement path.
package tick_period_meter_pkg;

    // Measurement FSM encoding.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STALL   = 2'd2
    } state_t;

    // System clock frequency, also used by the clock divider.
    localparam int unsigned CLK_HZ = 50000000;

    // Longest measurable period: one second of system clock.
    localparam int unsigned DEFAULT_TIMEOUT = CLK_HZ;

endpackage

// File: rtl/tick_period_meter_sync_edge_det.sv
// Three-flop synchroniser for an asynchronous level, producing one-cycle
// rise and fall strobes from the two settled stages.
module tick_period_meter_sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    // Shift the async input through three flops; s1 may go metastable.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Edge strobes compare the two settled stages only.
    always_comb begin
        rise = s2 & ~s3;
        fall = ~s2 & s3;
    end

endmodule

// File: rtl/tick_period_meter.sv
// Measures period and high time of a slow external tick in clk cycles,
// publishes one result per rising edge and flags a missing tick.
module tick_period_meter
    import tick_period_meter_pkg::*;
#(
    parameter int          CNT_W   = 32,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic [3:0]       edge_cnt
);

    // Counter value on the last cycle before a period counts as stalled.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, next_state;
    logic             rise, fall;
    logic [CNT_W-1:0] cnt, hi_cap;
    logic             start_meas, done_meas, hit_timeout, cap_high;

    tick_period_meter_sync_edge_det u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sig_in),
        .rise (rise),
        .fall (fall)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic; a rise always wins over the stall check.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (rise) next_state = MEASURE;
            MEASURE: if (!rise && cnt == CNT_LAST) next_state = STALL;
            STALL:   if (rise) next_state = MEASURE;
            default: next_state = IDLE;
        endcase
    end

    // Per-cycle action decode from state and edge strobes.
    always_comb begin
        start_meas  = rise && (state == IDLE || state == STALL);
        done_meas   = rise && (state == MEASURE);
        hit_timeout = !rise && (state == MEASURE) && (cnt == CNT_LAST);
        cap_high    = fall && (state == MEASURE);
    end

    // Counter, capture registers and published outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            hi_cap    <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
            edge_cnt  <= 4'd0;
        end else begin
            valid <= done_meas;

            // cnt restarts on every rise, freezes once the period has stalled.
            if (start_meas || done_meas)
                cnt <= '0;
            else if (state == MEASURE && !hit_timeout)
                cnt <= cnt + CNT_ONE;

            if (cap_high)
                hi_cap <= cnt + CNT_ONE;

            if (done_meas) begin
                period    <= cnt + CNT_ONE;
                high_time <= hi_cap;
                edge_cnt  <= edge_cnt + 4'd1;
            end

            if (hit_timeout)
                timeout <= 1'b1;
            else if (start_meas && state == STALL)
                timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tick_period_meter.sv
// Randomised and directed bench for tick_period_meter with a scoreboard
// fed by an edge-time reference model.
module tb_tick_period_meter;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 100;
    localparam int W       = 2 * CNT_W + 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             sig_in;
    logic [CNT_W-1:0] period, high_time;
    logic             valid, timeout;
    logic [3:0]       edge_cnt;

    tick_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .timeout   (timeout),
        .edge_cnt  (edge_cnt)
    );

    // Clock and cycle stamp used to time-tag input transitions.
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state.
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: measurement derived from input edge times.
    bit have_ref;
    int last_rise, last_fall;
    int exp_edges;
    int last_period, last_high;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        have_ref    = 1'b0;
        exp_edges   = 0;
        last_period = 0;
        last_high   = 0;
    endtask

    // A rise closes the running period unless none is open or it ran too long.
    task automatic model_rise(input int t);
        int p;
        if (have_ref) begin
            p = t - last_rise;
            if (p <= TIMEOUT) begin
                exp_edges   = (exp_edges + 1) % 16;
                last_period = p;
                last_high   = last_fall - last_rise;
                exp_q.push_back({CNT_W'(last_period), CNT_W'(last_high), 4'(exp_edges)});
            end
        end
        have_ref  = 1'b1;
        last_rise = t;
    endtask

    task automatic model_fall(input int t);
        last_fall = t;
    endtask

    // Driver tasks; inputs change 1 time unit after the rising edge.
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_sig(input logic v);
        if (v && !sig_in) model_rise(cyc);
        if (!v && sig_in) model_fall(cyc);
        sig_in = v;
    endtask

    task automatic pulse(input int hi, input int lo);
        set_sig(1'b1);
        wait_cyc(hi);
        set_sig(1'b0);
        wait_cyc(lo);
    endtask

    task automatic do_reset(input int n, input logic level);
        rst    = 1'b1;
        sig_in = level;
        wait_cyc(n);
        check("rst_period", 64'(period), 64'd0);
        check("rst_high", 64'(high_time), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_edge_cnt", 64'(edge_cnt), 64'd0);
        rst = 1'b0;
        model_reset();
        if (sig_in) model_rise(cyc);
    endtask

    // Monitor: every valid pulse must match the oldest expected measurement.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got valid=1 period=%0d expected no measurement (cycle %0d)",
                         period, cyc);
            end else begin
                e = exp_q.pop_front();
                check("period", 64'(period), 64'(e[W-1 -: CNT_W]));
                check("high_time", 64'(high_time), 64'(e[CNT_W+3 -: CNT_W]));
                check("edge_cnt", 64'(edge_cnt), 64'(e[3:0]));
                check("timeout_at_valid", 64'(timeout), 64'd0);
            end
        end
    end

    initial begin
        int t0, hi, lo;
        rst    = 1'b1;
        sig_in = 1'b0;
        model_reset();

        // Reset state.
        do_reset(3, 1'b0);

        // 20-cycle wave, high 8: 17 measurements, edge_cnt wraps back to 1.
        repeat (18) pulse(8, 12);
        check("wrap_edge_cnt", 64'(edge_cnt), 64'(exp_edges));
        check("wrap_period", 64'(period), 64'd20);

        // Period exactly TIMEOUT is reported; TIMEOUT+1 stalls.
        pulse(50, 50);
        t0 = cyc;
        set_sig(1'b1);
        wait_cyc(50);
        set_sig(1'b0);
        wait_cyc(51);
        set_sig(1'b1);
        wait_cyc(1);
        check("stall_pre", 64'(timeout), 64'(cyc - t0 >= TIMEOUT + 3));
        wait_cyc(1);
        check("stall_set", 64'(timeout), 64'(cyc - t0 >= TIMEOUT + 3));
        check("stall_period_hold", 64'(period), 64'd100);
        wait_cyc(1);
        check("stall_clear", 64'(timeout), 64'd0);
        wait_cyc(7);
        set_sig(1'b0);
        wait_cyc(10);
        pulse(8, 12);
        pulse(8, 12);

        // Long low after a 20/8 measurement: timeout, outputs hold.
        pulse(8, 292);
        check("hold_timeout", 64'(timeout), 64'd1);
        check("hold_period", 64'(period), 64'(last_period));
        check("hold_high", 64'(high_time), 64'(last_high));

        // Reset mid-measurement, then the wave resumes.
        set_sig(1'b1);
        wait_cyc(8);
        set_sig(1'b0);
        wait_cyc(45);
        do_reset(1, 1'b0);
        repeat (3) pulse(8, 12);
        check("post_rst_edge_cnt", 64'(edge_cnt), 64'(exp_edges));

        // Random wave, occasionally with periods long enough to stall.
        repeat (30) begin
            hi = $urandom_range(2, 40);
            lo = ($urandom_range(0, 5) == 0) ? $urandom_range(60, 120) : $urandom_range(2, 40);
            pulse(hi, lo);
        end

        // Input high through reset, then a 30/10 wave.
        do_reset(3, 1'b1);
        wait_cyc(10);
        set_sig(1'b0);
        wait_cyc(20);
        pulse(10, 20);
        pulse(10, 20);
        check("sig_high_rst_period", 64'(period), 64'd30);
        check("sig_high_rst_high", 64'(high_time), 64'd10);

        wait_cyc(10);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
